// File: rtl/dir_req_controller.sv
// Directory controller for two processors: a 4-entry MSI directory serving one request at a time,
// with invalidate/recall, write-back and fill handshakes towards the caches and memory.
module dir_req_controller (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [1:0] ReqValid,
    input  logic [1:0] ReqWrite,
    input  logic [3:0] ReqAddr0,
    input  logic [3:0] ReqAddr1,
    input  logic [3:0] ReqData0,
    input  logic [3:0] ReqData1,
    output logic [1:0] Grant,
    output logic [1:0] RespValid,
    output logic [3:0] RespData,
    output logic [1:0] RespState,
    output logic [1:0] InvValid,
    input  logic [1:0] InvAck,
    input  logic [3:0] InvData,
    output logic       MemReq,
    output logic       MemWe,
    output logic [3:0] MemAddr,
    output logic [3:0] MemWData,
    input  logic       MemAck,
    input  logic [3:0] MemData,
    output logic       Busy
);

    typedef enum logic [2:0] {IDLE, LOOKUP, INVAL, WB, FILL, REPLY} state_e;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_INV   = 2'b01;
    localparam logic [1:0] ST_SHR   = 2'b10;
    localparam logic [1:0] ST_MOD   = 2'b11;

    state_e     state_q, state_d;
    logic       reqIdx_q, reqIdx_d;
    logic       capWrite_q, capWrite_d;
    logic [3:0] capAddr_q, capAddr_d;
    logic [3:0] capData_q, capData_d;
    logic [1:0] entIdx_q, entIdx_d;
    logic       isMiss_q, isMiss_d;
    logic [1:0] invPend_q, invPend_d;
    logic       rrPtr_q, rrPtr_d;
    logic [1:0] victimPtr_q, victimPtr_d;
    logic [3:0] dirAddr_q [4];
    logic [3:0] dirAddr_d [4];
    logic [1:0] dirState_q [4];
    logic [1:0] dirState_d [4];
    logic [1:0] dirSh_q [4];
    logic [1:0] dirSh_d [4];
    logic [3:0] dirData_q [4];
    logic [3:0] dirData_d [4];

    logic [1:0] reqBit;
    logic       hit;
    logic [1:0] hitIdx;
    logic       emptyFound;
    logic [1:0] emptyIdx;
    logic [1:0] victim;
    logic       grantIdx;
    logic [1:0] acked;
    logic       doApply;

    assign reqBit   = reqIdx_q ? 2'b10 : 2'b01;
    assign grantIdx = (&ReqValid) ? rrPtr_q : ReqValid[1];
    assign Busy     = (state_q != IDLE);

    // Scanning downwards leaves the lowest matching/empty index as the winner.
    always_comb begin
        hit        = 1'b0;
        hitIdx     = 2'd0;
        emptyFound = 1'b0;
        emptyIdx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (dirState_q[i] != ST_EMPTY && dirAddr_q[i] == capAddr_q) begin
                hit    = 1'b1;
                hitIdx = 2'(i);
            end
            if (dirState_q[i] == ST_EMPTY) begin
                emptyFound = 1'b1;
                emptyIdx   = 2'(i);
            end
        end
        victim = emptyFound ? emptyIdx : victimPtr_q;
    end

    always_comb begin
        state_d     = state_q;
        reqIdx_d    = reqIdx_q;
        capWrite_d  = capWrite_q;
        capAddr_d   = capAddr_q;
        capData_d   = capData_q;
        entIdx_d    = entIdx_q;
        isMiss_d    = isMiss_q;
        invPend_d   = invPend_q;
        rrPtr_d     = rrPtr_q;
        victimPtr_d = victimPtr_q;
        dirAddr_d   = dirAddr_q;
        dirState_d  = dirState_q;
        dirSh_d     = dirSh_q;
        dirData_d   = dirData_q;
        Grant       = 2'b00;
        RespValid   = 2'b00;
        RespData    = 4'd0;
        RespState   = 2'b00;
        InvValid    = 2'b00;
        MemReq      = 1'b0;
        MemWe       = 1'b0;
        MemAddr     = 4'd0;
        MemWData    = 4'd0;
        acked       = InvAck & invPend_q;
        doApply     = 1'b0;

        case (state_q)
            IDLE: begin
                if ((|ReqValid) && Resetn) begin
                    Grant      = grantIdx ? 2'b10 : 2'b01;
                    reqIdx_d   = grantIdx;
                    capAddr_d  = grantIdx ? ReqAddr1 : ReqAddr0;
                    capData_d  = grantIdx ? ReqData1 : ReqData0;
                    capWrite_d = ReqWrite[grantIdx];
                    rrPtr_d    = ~grantIdx;
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                invPend_d = 2'b00;
                if (hit) begin
                    entIdx_d = hitIdx;
                    isMiss_d = 1'b0;
                    if (capWrite_q || (dirState_q[hitIdx] == ST_MOD && dirSh_q[hitIdx] != reqBit))
                        invPend_d = dirSh_q[hitIdx] & ~reqBit;
                    if (invPend_d != 2'b00) begin
                        state_d = INVAL;
                    end else begin
                        doApply = 1'b1;
                        state_d = REPLY;
                    end
                end else begin
                    entIdx_d  = victim;
                    isMiss_d  = 1'b1;
                    invPend_d = dirSh_q[victim];
                    if (!emptyFound)
                        victimPtr_d = victimPtr_q + 2'd1;
                    if (dirSh_q[victim] != 2'b00)
                        state_d = INVAL;
                    else if (dirState_q[victim] == ST_MOD)
                        state_d = WB;
                    else
                        state_d = FILL;
                end
            end
            INVAL: begin
                InvValid  = invPend_q;
                invPend_d = invPend_q & ~InvAck;
                // Only a modified owner returns live data; sharer acks carry nothing useful.
                if (dirState_q[entIdx_q] == ST_MOD && (acked & dirSh_q[entIdx_q]) != 2'b00)
                    dirData_d[entIdx_q] = InvData;
                if (invPend_d == 2'b00) begin
                    if (isMiss_q) begin
                        dirSh_d[entIdx_q] = 2'b00;
                        state_d = (dirState_q[entIdx_q] == ST_MOD) ? WB : FILL;
                    end else begin
                        doApply = 1'b1;
                        state_d = REPLY;
                    end
                end
            end
            WB: begin
                MemReq   = 1'b1;
                MemWe    = 1'b1;
                MemAddr  = dirAddr_q[entIdx_q];
                MemWData = dirData_q[entIdx_q];
                if (MemAck) begin
                    dirState_d[entIdx_q] = ST_INV;
                    state_d = FILL;
                end
            end
            FILL: begin
                MemReq  = 1'b1;
                MemAddr = capAddr_q;
                if (MemAck) begin
                    dirAddr_d[entIdx_q]  = capAddr_q;
                    dirData_d[entIdx_q]  = MemData;
                    dirSh_d[entIdx_q]    = 2'b00;
                    dirState_d[entIdx_q] = ST_INV;
                    doApply = 1'b1;
                    state_d = REPLY;
                end
            end
            REPLY: begin
                RespValid = reqBit;
                RespData  = dirData_q[entIdx_q];
                RespState = dirState_q[entIdx_q];
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Final access update, shared by the hit, post-invalidate and post-fill paths.
        if (doApply) begin
            if (capWrite_q) begin
                dirData_d[entIdx_d]  = capData_q;
                dirSh_d[entIdx_d]    = reqBit;
                dirState_d[entIdx_d] = ST_MOD;
            end else begin
                if (!(dirState_d[entIdx_d] == ST_MOD && dirSh_d[entIdx_d] == reqBit))
                    dirState_d[entIdx_d] = ST_SHR;
                dirSh_d[entIdx_d] = dirSh_d[entIdx_d] | reqBit;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= IDLE;
            reqIdx_q    <= 1'b0;
            capWrite_q  <= 1'b0;
            capAddr_q   <= 4'd0;
            capData_q   <= 4'd0;
            entIdx_q    <= 2'd0;
            isMiss_q    <= 1'b0;
            invPend_q   <= 2'b00;
            rrPtr_q     <= 1'b0;
            victimPtr_q <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                dirAddr_q[i]  <= 4'd0;
                dirState_q[i] <= ST_EMPTY;
                dirSh_q[i]    <= 2'b00;
                dirData_q[i]  <= 4'd0;
            end
        end else begin
            state_q     <= state_d;
            reqIdx_q    <= reqIdx_d;
            capWrite_q  <= capWrite_d;
            capAddr_q   <= capAddr_d;
            capData_q   <= capData_d;
            entIdx_q    <= entIdx_d;
            isMiss_q    <= isMiss_d;
            invPend_q   <= invPend_d;
            rrPtr_q     <= rrPtr_d;
            victimPtr_q <= victimPtr_d;
            dirAddr_q   <= dirAddr_d;
            dirState_q  <= dirState_d;
            dirSh_q     <= dirSh_d;
            dirData_q   <= dirData_d;
        end
    end

endmodule
